// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, byte/column/state types and the MixColumns FSM encoding.
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1b;

   typedef logic [7:0]   aes_byte_t;
   typedef logic [0:31]  aes_col_t;
   typedef logic [0:127] aes_state_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mixcol_state_e;

   // Row 0 coefficients; row r uses the same list rotated right by r.
   localparam logic [3:0] FWD_COEF [4] = '{4'h2, 4'h3, 4'h1, 4'h1};
   localparam logic [3:0] INV_COEF [4] = '{4'he, 4'hb, 4'hd, 4'h9};

   function automatic aes_byte_t xtime(input aes_byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic aes_byte_t gmul(input aes_byte_t b, input logic [3:0] k);
      aes_byte_t x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (k)
         4'h1:    return b;
         4'h2:    return x2;
         4'h3:    return x2 ^ b;
         4'h9:    return x8 ^ b;
         4'hb:    return x8 ^ x2 ^ b;
         4'hd:    return x8 ^ x4 ^ b;
         4'he:    return x8 ^ x4 ^ x2;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column (Inv)MixColumns; inv_i selects the inverse coefficient set.
module mix_column_unit
   import aes_pkg::*;
(
   input  aes_col_t col_i,
   input  logic     inv_i,
   output aes_col_t col_o
);

   aes_byte_t s [4];
   aes_byte_t acc;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      col_o = '0;
      acc   = '0;
      for (int r = 0; r < 4; r++) begin
         s[r] = col_i[24-8*r +: 8];
      end
      for (int r = 0; r < 4; r++) begin
         acc = '0;
         for (int j = 0; j < 4; j++) begin
            acc = acc ^ gmul(s[j], inv_i ? INV_COEF[2'(j - r)] : FWD_COEF[2'(j - r)]);
         end
         col_o[24-8*r +: 8] = acc;
      end
   end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock, valid/ready I/O.
// Define MIXCOL_INVERSE_EN to add the inv port selecting InvMixColumns per block.
module mix_columns_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  aes_state_t in_data,
`ifdef MIXCOL_INVERSE_EN
   input  logic       inv,
`endif
   output logic       out_valid,
   input  logic       out_ready,
   output aes_state_t out_data
);

   localparam int         LAT      = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_COL = 2'(COLS_PER_CYCLE * (LAT - 1));

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   mixcol_state_e state_q, state_d;
   logic [1:0]    col_q, col_d;
   aes_state_t    work_q, work_d;
   logic          blk_inv;
   logic          accept;

   logic [1:0]    unit_idx [COLS_PER_CYCLE];
   aes_col_t      unit_in  [COLS_PER_CYCLE];
   aes_col_t      unit_out [COLS_PER_CYCLE];

   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
      assign unit_idx[k] = col_q + 2'(k);
      assign unit_in[k]  = work_q[{unit_idx[k], 5'd0} +: 32];
      mix_column_unit u_col (
         .col_i (unit_in[k]),
         .inv_i (blk_inv),
         .col_o (unit_out[k])
      );
   end

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      work_d    = work_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: in_ready = 1'b1;
         BUSY: begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
               work_d[{unit_idx[k], 5'd0} +: 32] = unit_out[k];
            end
            col_d = col_q + COL_STEP;
            if (col_q == LAST_COL) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // An accept (from IDLE or a draining DONE) overrides the transitions above.
      if (in_valid && in_ready) begin
         state_d = BUSY;
         col_d   = '0;
         work_d  = in_data;
      end
   end

   assign accept   = in_valid && in_ready;
   assign out_data = work_q;

   // NOTE: state uses non-blocking assignments; the work register is reset too because out_data must read 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         work_q  <= work_d;
      end
   end

`ifdef MIXCOL_INVERSE_EN
   always_ff @(posedge clk) begin
      if (rst)         blk_inv <= 1'b0;
      else if (accept) blk_inv <= inv;
   end
`else
   assign blk_inv = 1'b0;
`endif

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2, 4 against a matrix-level GF(2^8) model.
module tb_mix_columns_seq;
   import aes_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst;
   logic       in_valid  [3];
   logic       in_ready  [3];
   logic       out_valid [3];
   logic       out_ready [3];
   aes_state_t in_data   [3];
   aes_state_t out_data  [3];
`ifdef MIXCOL_INVERSE_EN
   logic       inv       [3];
`endif

   for (genvar d = 0; d < 3; d++) begin : g_dut
      mix_columns_seq #(.COLS_PER_CYCLE(1 << d)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[d]),
         .in_ready  (in_ready[d]),
         .in_data   (in_data[d]),
`ifdef MIXCOL_INVERSE_EN
         .inv       (inv[d]),
`endif
         .out_valid (out_valid[d]),
         .out_ready (out_ready[d]),
         .out_data  (out_data[d])
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: state as a 4x4 byte matrix times a fixed GF(2^8) matrix.
   function automatic int gf_mul(input int a, input int b);
      int p = 0;
      for (int i = 0; i < 8; i++) begin
         if ((b & 1) != 0) p = p ^ a;
         b = b >> 1;
         a = a << 1;
         if ((a & 'h100) != 0) a = a ^ 'h11b;
      end
      return p & 'hff;
   endfunction

   function automatic aes_state_t ref_mix(input aes_state_t s, input bit inverse);
      int fm [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
      int im [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
      aes_state_t o = '0;
      int acc;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gf_mul(inverse ? im[r][j] : fm[r][j], int'(s[c*32+24-8*j +: 8]));
            o[c*32+24-8*r +: 8] = 8'(acc);
         end
      end
      return o;
   endfunction

   task automatic send(input int d, input aes_state_t data);
      int w = 0;
      in_data[d]  = data;
      in_valid[d] = 1'b1;
      while (!in_ready[d] && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check("accept_wait", in_ready[d], 1'b1);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic wait_out(input int d, output int n);
      n = 0;
      while (!out_valid[d] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_block(input int d, input aes_state_t data, input aes_state_t exp, input string name);
      int n;
      out_ready[d] = 1'b1;
      send(d, data);
      wait_out(d, n);
      check({name, "_latency"}, n, 4 >> d);
      check({name, "_data"}, out_data[d], exp);
      @(posedge clk); #1;
      check({name, "_drained"}, out_valid[d], 1'b0);
   endtask

   typedef struct {
      aes_col_t din;
      aes_col_t dexp;
   } vec_t;

   vec_t       tbl [6];
   aes_state_t fips_in, blk, exp_blk, held, blk_a, blk_b, x, y;
   int         n, t_a, t_b, stale;

   initial begin
      tbl[0] = '{32'h4553_13db, 32'hbca1_4d8e};
      tbl[1] = '{32'h5c22_0af2, 32'h9d58_dc9f};
      tbl[2] = '{32'h0101_0101, 32'h0101_0101};
      tbl[3] = '{32'hc6c6_c6c6, 32'hc6c6_c6c6};
      tbl[4] = '{32'hd5d4_d4d4, 32'hd6d7_d5d5};
      tbl[5] = '{32'h4c31_262d, 32'hf8bd_7e4d};
      fips_in = {32'h4553_13db, 32'hf20a_225c, 32'h0101_0101, 32'hd5d4_d4d4};

      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b1;
         in_data[d]   = '0;
`ifdef MIXCOL_INVERSE_EN
         inv[d]       = 1'b0;
`endif
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset_in_ready_%0d", d), in_ready[d], 1'b1);
         check($sformatf("reset_out_valid_%0d", d), out_valid[d], 1'b0);
         check($sformatf("reset_out_data_%0d", d), out_data[d], '0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // FIPS block at every width: latency 4/COLS_PER_CYCLE, identical data.
      for (int d = 0; d < 3; d++) begin
         run_block(d, fips_in, ref_mix(fips_in, 1'b0), $sformatf("fips_%0d", d));
         check($sformatf("fips_col0_%0d", d), out_data[d][0:31], 32'hbca1_4d8e);
         check($sformatf("fips_col2_%0d", d), out_data[d][64:95], 32'h0101_0101);
      end

      // Known column vectors, rotated through all four column slots.
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 4; k++) begin
            blk[k*32 +: 32]     = tbl[(i + k) % 6].din;
            exp_blk[k*32 +: 32] = tbl[(i + k) % 6].dexp;
         end
         run_block(i % 3, blk, exp_blk, $sformatf("table_%0d", i));
      end

      // Backpressure: result held, input side closed.
      out_ready[0] = 1'b0;
      send(0, fips_in);
      wait_out(0, n);
      check("bp_latency", n, 4);
      held = ref_mix(fips_in, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", out_valid[0], 1'b1);
         check("bp_hold_data", out_data[0], held);
         check("bp_in_ready", in_ready[0], 1'b0);
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      check("bp_release", out_valid[0], 1'b0);

      // Back-to-back: second accept coincides with first output transfer.
      blk_a = {$urandom, $urandom, $urandom, $urandom};
      blk_b = {$urandom, $urandom, $urandom, $urandom};
      in_data[0]  = blk_a;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_data[0] = blk_b;
      wait_out(0, n);
      t_a = cyc;
      check("b2b_first_latency", n, 4);
      check("b2b_first_data", out_data[0], ref_mix(blk_a, 1'b0));
      check("b2b_in_ready_in_done", in_ready[0], 1'b1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check("b2b_valid_drops", out_valid[0], 1'b0);
      check("b2b_second_busy", in_ready[0], 1'b0);
      wait_out(0, n);
      t_b = cyc;
      check("b2b_spacing", t_b - t_a, 5);
      check("b2b_second_data", out_data[0], ref_mix(blk_b, 1'b0));
      @(posedge clk); #1;
      check("b2b_drained", out_valid[0], 1'b0);

      // Reset during the second BUSY cycle abandons the block.
      in_data[0]  = fips_in;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", out_valid[0], 1'b0);
      check("midrst_in_ready", in_ready[0], 1'b1);
      check("midrst_out_data", out_data[0], '0);
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid[0]) stale++;
      end
      check("midrst_no_stale", stale, 0);

      // Random states at every width.
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            run_block(d, x, ref_mix(x, 1'b0), $sformatf("rand_%0d_%0d", d, i));
         end
      end

`ifdef MIXCOL_INVERSE_EN
      for (int d = 0; d < 3; d++) begin
         inv[d] = 1'b1;
         run_block(d, ref_mix(fips_in, 1'b0), fips_in, $sformatf("inv_fips_%0d", d));
         check($sformatf("inv_col0_%0d", d), out_data[d][0:31], 32'h4553_13db);
         inv[d] = 1'b0;
      end
      for (int i = 0; i < 1000; i++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         y = ref_mix(x, 1'b0);
         inv[i % 3] = 1'b0;
         run_block(i % 3, x, y, $sformatf("rt_fwd_%0d", i));
         inv[i % 3] = 1'b1;
         run_block(i % 3, y, x, $sformatf("rt_inv_%0d", i));
         inv[i % 3] = 1'b0;
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
